// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bus: ID-side capture inputs, pipeline control, and EX-side registered copies.
interface id_ex_pipe_reg_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FUNCT_W = 10,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 16
);
  logic               stall_i;
  logic               flush_i;
  logic               valid_i;
  logic [1:0]         ALUOp_i;
  logic               ALUSrc_i;
  logic               Branch_i;
  logic               MemRead_i;
  logic               MemWrite_i;
  logic               RegWrite_i;
  logic               MemtoReg_i;
  logic [DATA_W-1:0]  RS1data_i;
  logic [DATA_W-1:0]  RS2data_i;
  logic [DATA_W-1:0]  imm_i;
  logic [DATA_W-1:0]  pc_i;
  logic [FUNCT_W-1:0] funct_i;
  logic [REG_AW-1:0]  RS1addr_i;
  logic [REG_AW-1:0]  RS2addr_i;
  logic [REG_AW-1:0]  RDaddr_i;

  logic               valid_o;
  logic [1:0]         ALUOp_o;
  logic               ALUSrc_o;
  logic               Branch_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic               RegWrite_o;
  logic               MemtoReg_o;
  logic [DATA_W-1:0]  RS1data_o;
  logic [DATA_W-1:0]  RS2data_o;
  logic [DATA_W-1:0]  imm_o;
  logic [DATA_W-1:0]  pc_o;
  logic [FUNCT_W-1:0] funct_o;
  logic [REG_AW-1:0]  RS1addr_o;
  logic [REG_AW-1:0]  RS2addr_o;
  logic [REG_AW-1:0]  RDaddr_o;
  logic [CNT_W-1:0]   bubble_cnt_o;

  modport master (
    output stall_i, flush_i, valid_i, ALUOp_i, ALUSrc_i, Branch_i, MemRead_i,
           MemWrite_i, RegWrite_i, MemtoReg_i, RS1data_i, RS2data_i, imm_i, pc_i,
           funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
    input  valid_o, ALUOp_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o,
           MemtoReg_o, RS1data_o, RS2data_o, imm_o, pc_o, funct_o, RS1addr_o,
           RS2addr_o, RDaddr_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, ALUOp_i, ALUSrc_i, Branch_i, MemRead_i,
           MemWrite_i, RegWrite_i, MemtoReg_i, RS1data_i, RS2data_i, imm_i, pc_i,
           funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
    output valid_o, ALUOp_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o,
           MemtoReg_o, RS1data_o, RS2data_o, imm_o, pc_o, funct_o, RS1addr_o,
           RS2addr_o, RDaddr_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, flush-to-bubble and a saturating count of bubbles entering EX.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FUNCT_W = 10,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  id_ex_pipe_reg_if.slave bus
);

  logic               valid;
  logic [1:0]         aluOp;
  logic               aluSrc;
  logic               branch;
  logic               memRead;
  logic               memWrite;
  logic               regWrite;
  logic               memToReg;
  logic [DATA_W-1:0]  rs1Data;
  logic [DATA_W-1:0]  rs2Data;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]  pc;
  logic [FUNCT_W-1:0] funct;
  logic [REG_AW-1:0]  rs1Addr;
  logic [REG_AW-1:0]  rs2Addr;
  logic [REG_AW-1:0]  rdAddr;
  logic [CNT_W-1:0]   bubbleCnt;

  logic ctrlZero;
  logic isBubble;

  // An all-zero control word is what the upstream hazard mux emits, so it counts as a bubble.
  always_comb begin
    ctrlZero = ~|{bus.ALUOp_i, bus.ALUSrc_i, bus.Branch_i, bus.MemRead_i,
                  bus.MemWrite_i, bus.RegWrite_i, bus.MemtoReg_i};
    isBubble = bus.flush_i | ~bus.valid_i | ctrlZero;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid     <= 1'b0;
      aluOp     <= '0;
      aluSrc    <= 1'b0;
      branch    <= 1'b0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      regWrite  <= 1'b0;
      memToReg  <= 1'b0;
      rs1Data   <= '0;
      rs2Data   <= '0;
      imm       <= '0;
      pc        <= '0;
      funct     <= '0;
      rs1Addr   <= '0;
      rs2Addr   <= '0;
      rdAddr    <= '0;
      bubbleCnt <= '0;
    end else if (bus.flush_i || !bus.stall_i) begin
      if (bus.flush_i) begin
        valid     <= 1'b0;
        aluOp     <= '0;
        aluSrc    <= 1'b0;
        branch    <= 1'b0;
        memRead   <= 1'b0;
        memWrite  <= 1'b0;
        regWrite  <= 1'b0;
        memToReg  <= 1'b0;
        rs1Data   <= '0;
        rs2Data   <= '0;
        imm       <= '0;
        pc        <= '0;
        funct     <= '0;
        rs1Addr   <= '0;
        rs2Addr   <= '0;
        rdAddr    <= '0;
      end else begin
        // Control is masked by valid_i so an invalid entry can never write state downstream.
        valid     <= bus.valid_i;
        aluOp     <= bus.valid_i ? bus.ALUOp_i : 2'b00;
        aluSrc    <= bus.valid_i & bus.ALUSrc_i;
        branch    <= bus.valid_i & bus.Branch_i;
        memRead   <= bus.valid_i & bus.MemRead_i;
        memWrite  <= bus.valid_i & bus.MemWrite_i;
        regWrite  <= bus.valid_i & bus.RegWrite_i;
        memToReg  <= bus.valid_i & bus.MemtoReg_i;
        rs1Data   <= bus.RS1data_i;
        rs2Data   <= bus.RS2data_i;
        imm       <= bus.imm_i;
        pc        <= bus.pc_i;
        funct     <= bus.funct_i;
        rs1Addr   <= bus.RS1addr_i;
        rs2Addr   <= bus.RS2addr_i;
        rdAddr    <= bus.RDaddr_i;
      end
      if (isBubble && (bubbleCnt != '1)) begin
        bubbleCnt <= bubbleCnt + 1'b1;
      end
    end
  end

  assign bus.valid_o      = valid;
  assign bus.ALUOp_o      = aluOp;
  assign bus.ALUSrc_o     = aluSrc;
  assign bus.Branch_o     = branch;
  assign bus.MemRead_o    = memRead;
  assign bus.MemWrite_o   = memWrite;
  assign bus.RegWrite_o   = regWrite;
  assign bus.MemtoReg_o   = memToReg;
  assign bus.RS1data_o    = rs1Data;
  assign bus.RS2data_o    = rs2Data;
  assign bus.imm_o        = imm;
  assign bus.pc_o         = pc;
  assign bus.funct_o      = funct;
  assign bus.RS1addr_o    = rs1Addr;
  assign bus.RS2addr_o    = rs2Addr;
  assign bus.RDaddr_o     = rdAddr;
  assign bus.bubble_cnt_o = bubbleCnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, load, stall, flush, hazard bubble, valid masking, counter saturation.
module tb_id_ex_pipe_reg;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  id_ex_pipe_reg_if #(.DATA_W(32), .FUNCT_W(10), .REG_AW(5), .CNT_W(4)) bus ();

  id_ex_pipe_reg #(.DATA_W(32), .FUNCT_W(10), .REG_AW(5), .CNT_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    bus.stall_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.valid_i    = 1'b0;
    bus.ALUOp_i    = 2'b00;
    bus.ALUSrc_i   = 1'b0;
    bus.Branch_i   = 1'b0;
    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b0;
    bus.RegWrite_i = 1'b0;
    bus.MemtoReg_i = 1'b0;
    bus.RS1data_i  = '0;
    bus.RS2data_i  = '0;
    bus.imm_i      = '0;
    bus.pc_i       = '0;
    bus.funct_i    = '0;
    bus.RS1addr_i  = '0;
    bus.RS2addr_i  = '0;
    bus.RDaddr_i   = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clearInputs();
    tick();
    tick();
    chk("reset valid_o", {31'd0, bus.valid_o}, 32'd0);
    chk("reset cnt", {28'd0, bus.bubble_cnt_o}, 32'd0);

    // First load after release captures every field
    rst_n          = 1'b1;
    bus.valid_i    = 1'b1;
    bus.RegWrite_i = 1'b1;
    bus.MemtoReg_i = 1'b1;
    bus.Branch_i   = 1'b1;
    bus.RS1data_i  = 32'h1234_5678;
    bus.RS2data_i  = 32'hCAFE_0001;
    bus.funct_i    = 10'h2A5;
    bus.RS1addr_i  = 5'd3;
    bus.RS2addr_i  = 5'd30;
    bus.RDaddr_i   = 5'd7;
    tick();
    chk("load RS1data_o", bus.RS1data_o, 32'h1234_5678);
    chk("load RS2data_o", bus.RS2data_o, 32'hCAFE_0001);
    chk("load RDaddr_o", {27'd0, bus.RDaddr_o}, 32'd7);
    chk("load RS1addr_o", {27'd0, bus.RS1addr_o}, 32'd3);
    chk("load RS2addr_o", {27'd0, bus.RS2addr_o}, 32'd30);
    chk("load funct_o", {22'd0, bus.funct_o}, 32'h2A5);
    chk("load ctrl", {28'd0, bus.RegWrite_o, bus.MemtoReg_o, bus.Branch_o, bus.valid_o}, 32'hF);
    chk("load cnt", {28'd0, bus.bubble_cnt_o}, 32'd0);

    // One flush for a nonzero count, then a real load, then async reset mid-cycle
    bus.flush_i = 1'b1;
    tick();
    chk("flush cnt", {28'd0, bus.bubble_cnt_o}, 32'd1);
    bus.flush_i = 1'b0;
    tick();
    chk("reload RS1data_o", bus.RS1data_o, 32'h1234_5678);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst RS1data_o", bus.RS1data_o, 32'd0);
    chk("async rst RDaddr_o", {27'd0, bus.RDaddr_o}, 32'd0);
    chk("async rst ctrl", {28'd0, bus.RegWrite_o, bus.MemtoReg_o, bus.Branch_o, bus.valid_o}, 32'd0);
    chk("async rst cnt", {28'd0, bus.bubble_cnt_o}, 32'd0);
    tick();

    // Stall hold
    rst_n = 1'b1;
    clearInputs();
    bus.valid_i    = 1'b1;
    bus.ALUSrc_i   = 1'b1;
    bus.RegWrite_i = 1'b1;
    bus.pc_i       = 32'h40;
    tick();
    chk("pre-stall pc_o", bus.pc_o, 32'h40);
    bus.stall_i = 1'b1;
    bus.pc_i    = 32'h44;
    tick();
    chk("stall1 pc_o", bus.pc_o, 32'h40);
    bus.pc_i    = 32'h48;
    bus.valid_i = 1'b0;
    tick();
    chk("stall2 pc_o", bus.pc_o, 32'h40);
    chk("stall2 valid_o", {31'd0, bus.valid_o}, 32'd1);
    bus.valid_i = 1'b1;
    tick();
    chk("stall3 pc_o", bus.pc_o, 32'h40);
    chk("stall cnt", {28'd0, bus.bubble_cnt_o}, 32'd0);
    bus.stall_i = 1'b0;
    tick();
    chk("unstall pc_o", bus.pc_o, 32'h48);

    // Flush wins over stall
    bus.stall_i    = 1'b1;
    bus.flush_i    = 1'b1;
    bus.MemWrite_i = 1'b1;
    bus.imm_i      = 32'hFFFF_FFF0;
    tick();
    chk("flush MemWrite_o", {31'd0, bus.MemWrite_o}, 32'd0);
    chk("flush imm_o", bus.imm_o, 32'd0);
    chk("flush pc_o", bus.pc_o, 32'd0);
    chk("flush valid_o", {31'd0, bus.valid_o}, 32'd0);
    chk("flush+stall cnt", {28'd0, bus.bubble_cnt_o}, 32'd1);

    // Hazard bubble: valid but all control zero
    clearInputs();
    bus.valid_i   = 1'b1;
    bus.RS1data_i = 32'hAAAA_5555;
    tick();
    chk("hazard ctrl", {24'd0, bus.ALUOp_o, bus.ALUSrc_o, bus.Branch_o, bus.MemRead_o,
                        bus.MemWrite_o, bus.RegWrite_o, bus.MemtoReg_o}, 32'd0);
    chk("hazard RS1data_o", bus.RS1data_o, 32'hAAAA_5555);
    chk("hazard cnt", {28'd0, bus.bubble_cnt_o}, 32'd2);
    bus.RegWrite_i = 1'b1;
    tick();
    chk("normal RegWrite_o", {31'd0, bus.RegWrite_o}, 32'd1);
    chk("normal cnt", {28'd0, bus.bubble_cnt_o}, 32'd2);

    // valid_i=0 masks nonzero control
    bus.valid_i    = 1'b0;
    bus.MemRead_i  = 1'b1;
    bus.ALUOp_i    = 2'b10;
    tick();
    chk("mask ctrl", {26'd0, bus.ALUOp_o, bus.RegWrite_o, bus.MemRead_o, bus.valid_o}, 32'd0);
    chk("mask cnt", {28'd0, bus.bubble_cnt_o}, 32'd3);

    // Saturation at 15 with CNT_W=4
    clearInputs();
    bus.flush_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sat cnt step%0d", k), {28'd0, bus.bubble_cnt_o},
          (3 + k > 15) ? 32'd15 : 32'(3 + k));
    end
    #2 rst_n = 1'b0;
    #1;
    chk("sat reset cnt", {28'd0, bus.bubble_cnt_o}, 32'd0);
    tick();
    chk("held reset cnt", {28'd0, bus.bubble_cnt_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32 core.
- Sits directly downstream of the hazard control-zeroing mux in ID. Captures the muxed control bits plus decoded operands, register addresses and PC, and presents them to EX, the forwarding unit and the hazard unit.
- Supports hold (stall_i) and bubble injection (flush_i).
- Keeps a saturating count of bubbles that enter EX.

Parameters:
- DATA_W, 32, width of the operand, immediate and PC fields
- FUNCT_W, 10, width of the {funct7, funct3} field
- REG_AW, 5, width of the register-address fields
- CNT_W, 16, width of the bubble counter

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  asynchronous, active-low reset
- stall_i  input  1  hold all state this cycle
- flush_i  input  1  load a bubble this cycle
- valid_i  input  1  the ID-stage instruction is real (not a bubble)
- ALUOp_i  input  2  control from the ID mux
- ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i  input  1 each  control from the ID mux
- RS1data_i, RS2data_i  input  DATA_W  register-file read data
- imm_i  input  DATA_W  sign-extended immediate
- pc_i  input  DATA_W  PC of the ID instruction
- funct_i  input  FUNCT_W  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  input  REG_AW  register addresses
- Each *_i data/control input has a registered *_o counterpart of the same width, output, holding the EX-stage copy (ALUOp_o … RDaddr_o).
- valid_o  output  1  the EX-stage entry is a real instruction
- bubble_cnt_o  output  CNT_W  saturating count of bubbles loaded

Behaviour:
- Reset (rst_i=0, asynchronous, takes effect without waiting for a clock edge):
  - every *_o = 0, valid_o = 0, bubble_cnt_o = 0;
  - held while rst_i is low;
  - the first capture happens on the first rising edge after rst_i goes high.
- Per rising edge, in priority order:
  - 1) flush_i=1: load a bubble. All control outputs = 0, valid_o = 0, all data/address/funct/pc outputs = 0. Flush overrides stall.
  - 2) stall_i=1 (flush_i=0): every register, including bubble_cnt_o, holds its value.
  - 3) otherwise: load. Every *_o <= *_i, valid_o <= valid_i.
- Latency: exactly one cycle from input to output; no combinational path from inputs to outputs.
- Bubble counting:
  - A "bubble load" is either a flush, or a normal load with valid_i=0 or with every control input = 0. The all-zero case is what the upstream mux produces on a hazard.
  - On a bubble load, bubble_cnt_o increments by 1.
  - It saturates at 2^CNT_W-1: no wrap, and the all-ones value is held.
  - Stalled cycles are never counted.
- Consistency:
  - A registered entry with valid_o=0 always has RegWrite_o = MemWrite_o = MemRead_o = Branch_o = 0.
  - On a normal load with valid_i=0, control outputs are forced to 0 even if the control inputs are nonzero.
- Simultaneous stall_i=1 and flush_i=1: the flush wins, and the bubble is counted.
- Reset asserted during a stall or flush sequence: reset wins immediately and all state clears.
- No X propagation: with all inputs known, outputs are known from the first edge after reset.

Test Plan:
- Reset → outputs zero, then load:
  - Assert rst_i=0 mid-cycle with prior nonzero state → all *_o = 0, valid_o = 0 and bubble_cnt_o = 0 before the next edge.
  - Release reset; load RS1data_i=32'h1234_5678, RDaddr_i=5'd7, RegWrite_i=1, valid_i=1 → after 1 edge, RS1data_o=32'h1234_5678, RDaddr_o=7, RegWrite_o=1, valid_o=1.
- Stall hold:
  - With an entry holding pc_o=32'h40, hold stall_i=1 for 3 cycles while pc_i changes to 32'h44 and 32'h48 → pc_o stays 32'h40 and bubble_cnt_o is unchanged.
  - Deassert stall_i → pc_o takes the current pc_i on the next edge.
- Flush over stall:
  - stall_i=1 and flush_i=1 with MemWrite_i=1, imm_i=32'hFFFF_FFF0 → next edge: MemWrite_o=0, imm_o=0, valid_o=0, bubble_cnt_o +1.
- Hazard bubble from the mux:
  - valid_i=1 with all control inputs 0 (load-use stall) → control outputs all 0 and bubble_cnt_o +1.
  - The next normal instruction with RegWrite_i=1 → bubble_cnt_o unchanged.
- valid_i=0 masking:
  - valid_i=0 with RegWrite_i=1, MemRead_i=1, ALUOp_i=2'b10 → RegWrite_o=0, MemRead_o=0, ALUOp_o=0, valid_o=0, and the bubble is counted.
- Counter saturation (CNT_W=4):
  - Run 20 consecutive flushes → bubble_cnt_o reaches 15 and stays 15.
  - Reset returns it to 0.
